param_updown_counter: RTL
=========================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter/data width (2..32).
REQ-002 Parameter RESET_VAL, default 0, count value after reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  count enable for modes UP/DOWN.
REQ-006 mode  input  2  operation: 00 HOLD, 01 UP, 10 DOWN, 11 LOAD.
REQ-007 data_in  input  WIDTH  load value for LOAD mode and limit_load.
REQ-008 limit_load  input  1  strobe: capture data_in into limit register.
REQ-009 clear_flags  input  1  clears sticky wrap flag.
REQ-010 out_enable  input  1  pad-driver enable request.
REQ-011 q  output  WIDTH  current count, always valid irrespective of out_enable.
REQ-012 q_oe  output  WIDTH  per-bit pad enable, all bits equal to out_enable (combinational).
REQ-013 tc  output  1  registered terminal-count pulse, one cycle.
REQ-014 wrap_sticky  output  1  set on any wrap, held until clear_flags.

Function
REQ-015 LOAD (mode 11) SHALL set q=data_in next edge, regardless of en; tc=0 that cycle.
REQ-016 HOLD, or UP/DOWN with en=0, SHALL keep q unchanged, tc=0.
REQ-017 UP with en=1: q<limit -> q+1; q>=limit -> q=0, tc=1, wrap_sticky=1.
REQ-018 DOWN with en=1: q>0 -> q-1; q==0 -> q=limit, tc=1, wrap_sticky=1.
REQ-019 Limit register SHALL reset to all ones (modulo 2^WIDTH behaviour).
REQ-020 limit_load SHALL update the limit at the edge; a count in the same cycle SHALL compare against the old limit.
REQ-021 LOAD value above limit SHALL be accepted as-is; next UP step wraps to 0 per REQ-017.
REQ-022 limit=0: UP holds q at 0 with tc=1 each enabled cycle; DOWN same.
REQ-023 tc SHALL be a single-cycle pulse, registered, asserted in the cycle after the wrapping edge is visible on q.
REQ-024 clear_flags and a wrap in the same cycle: set wins, wrap_sticky=1.
REQ-025 Count arithmetic SHALL be WIDTH bits, no carry-out beyond tc.
REQ-026 out_enable SHALL not affect counting or q; only q_oe.

Reset
REQ-027 rst_n low SHALL immediately force q=RESET_VAL, limit=all ones, tc=0, wrap_sticky=0.
REQ-028 Reset asserted mid-count SHALL abandon the operation; first post-release edge obeys mode normally.
REQ-029 q_oe SHALL follow out_enable during reset (no registered state).

Structure
REQ-030 Shared package param_counter_pkg SHALL hold the mode encoding constants (MODE_HOLD, MODE_UP, MODE_DOWN, MODE_LOAD).
REQ-031 Single module; no sub-module; the top-level wrapper maps ui_in bits to mode/en/out_enable and uio to data_in/q with uio_oe=q_oe.

Verification
REQ-032 Reset release, mode UP en=1, WIDTH=8, 300 cycles -> q counts 0..255, wraps to 0, tc pulses at cycles 256, wrap_sticky=1.
REQ-033 limit_load data_in=5, then UP -> q 0,1,2,3,4,5,0; tc once per wrap; DOWN from 0 -> q=5.
REQ-034 LOAD data_in=200 with limit=5, then UP -> q=200 then 0, tc=1.
REQ-035 limit_load=1 with data_in=3 and UP same cycle at q=3 (old limit 255) -> q=4; next UP with q=4>=3 -> 0.
REQ-036 clear_flags asserted during wrap cycle -> wrap_sticky stays 1; clear alone next cycle -> 0.
REQ-037 rst_n low asynchronously mid-count at q=77 -> q=RESET_VAL without clock edge; toggle out_enable -> q_oe 00/FF while q unchanged.

Source files
------------

// File: rtl/param_counter_pkg.sv
// param_counter_pkg: shared mode encoding for the up/down counter.
package param_counter_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
endpackage

// File: rtl/param_updown_counter.sv
// param_updown_counter: up/down counter with loadable wrap limit, registered tc pulse and sticky wrap flag.
module param_updown_counter
  import param_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             limit_load,
  input  logic             clear_flags,
  input  logic             out_enable,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_oe,
  output logic             tc,
  output logic             wrap_sticky
);
  logic [WIDTH-1:0] cnt_q, cnt_d, limit_q, limit_d;
  logic tc_q, tc_d, wrap_q, wrap_d, up, dn, at_top, at_zero;
  always_comb begin
    up      = (mode == MODE_UP) && en;
    dn      = (mode == MODE_DOWN) && en;
    at_top  = cnt_q >= limit_q;
    at_zero = cnt_q == '0;
    // counting always compares against the limit held before this edge
    limit_d = limit_load ? data_in : limit_q;
    tc_d    = (up && at_top) || (dn && at_zero);
    wrap_d  = tc_d || (wrap_q && !clear_flags);
    cnt_d   = (mode == MODE_LOAD) ? data_in :
              up ? (at_top ? '0 : cnt_q + 1'b1) :
              dn ? (at_zero ? limit_q : cnt_q - 1'b1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= WIDTH'(RESET_VAL);
      limit_q <= '1;
      tc_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
    end
  end
  assign q           = cnt_q;
  assign q_oe        = {WIDTH{out_enable}};
  assign tc          = tc_q;
  assign wrap_sticky = wrap_q;
endmodule
